// File: rtl/uart_pkg.sv
// Shared UART definitions for the rx and tx buffers: frame constants and the
// transmit serializer state encoding.
package uart_pkg;

  localparam int UART_DATA_BITS = 8;

  localparam logic UART_START_BIT  = 1'b0;
  localparam logic UART_STOP_BIT   = 1'b1;
  localparam logic UART_IDLE_LEVEL = 1'b1;

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_START = 2'd1,
    TX_DATA  = 2'd2,
    TX_STOP  = 2'd3
  } tx_state_e;

endpackage

// File: rtl/uart_tx_buffer_if.sv
// Producer-side bus of the UART transmit buffer: byte enqueue strobe plus
// FIFO status returned to the producer.
interface uart_tx_buffer_if #(
  parameter int FIFO_DEPTH = 16
);
  localparam int LW = $clog2(FIFO_DEPTH + 1);

  logic [7:0]    wrData;
  logic          wrEn;
  logic          full;
  logic          empty;
  logic [LW-1:0] level;
  logic          overflow;

  modport master (
    output wrData,
    output wrEn,
    input  full,
    input  empty,
    input  level,
    input  overflow
  );

  modport slave (
    input  wrData,
    input  wrEn,
    output full,
    output empty,
    output level,
    output overflow
  );
endinterface

// File: rtl/uart_sync_fifo.sv
// Single-clock circular FIFO with occupancy counter and registered full/empty
// flags; the read data is the current head entry.
module uart_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           wdata,
  output logic [WIDTH-1:0]           rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [LW-1:0]    count_r;
  logic [LW-1:0]    count_s;
  logic             full_r;
  logic             empty_r;
  logic             do_push_s;
  logic             do_pop_s;

  // Flags are taken from the pre-edge state, so a push while full is dropped
  // even when a pop happens on the same edge.
  assign do_push_s = push && !full_r;
  assign do_pop_s  = pop && !empty_r;

  // Next occupancy from the accepted push/pop pair.
  always_comb begin
    count_s = count_r;
    case ({do_push_s, do_pop_s})
      2'b10:   count_s = count_r + LW'(1);
      2'b01:   count_s = count_r - LW'(1);
      default: count_s = count_r;
    endcase
  end

  // Pointers, occupancy and status flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
      full_r   <= 1'b0;
      empty_r  <= 1'b1;
    end else begin
      if (do_push_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      count_r <= count_s;
      full_r  <= (count_s == LW'(DEPTH));
      empty_r <= (count_s == LW'(0));
    end
  end

  // Storage array; contents need no reset because empty guards every read.
  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem_r[wr_ptr_r] <= wdata;
    end
  end

  assign rdata = mem_r[rd_ptr_r];
  assign full  = full_r;
  assign empty = empty_r;
  assign level = count_r;

endmodule

// File: rtl/uart_tx_buffer.sv
// Buffered 8N1 UART transmitter: bytes queue in a FIFO and are serialized
// LSB first, back-to-back, CLKS_PER_BIT clocks per bit.
module uart_tx_buffer
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 1,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic             uartClk,
  input  logic             nReset,
  uart_tx_buffer_if.slave  bus,
  output logic             busy,
  output logic             tx
);

  localparam int LW = $clog2(FIFO_DEPTH + 1);
  localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [2:0]    BIT_LAST  = 3'(UART_DATA_BITS - 1);

  tx_state_e                 state_r;
  tx_state_e                 state_s;
  logic [BW-1:0]             baud_r;
  logic [BW-1:0]             baud_s;
  logic [2:0]                bit_r;
  logic [2:0]                bit_s;
  logic [UART_DATA_BITS-1:0] shift_r;
  logic [UART_DATA_BITS-1:0] shift_s;
  logic                      tx_r;
  logic                      tx_s;
  logic                      busy_r;
  logic                      overflow_r;
  logic                      pop_s;
  logic [UART_DATA_BITS-1:0] head_s;
  logic                      full_s;
  logic                      empty_s;
  logic [LW-1:0]             level_s;

  uart_sync_fifo #(
    .WIDTH (UART_DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (uartClk),
    .rst_n (nReset),
    .push  (bus.wrEn),
    .pop   (pop_s),
    .wdata (bus.wrData),
    .rdata (head_s),
    .full  (full_s),
    .empty (empty_s),
    .level (level_s)
  );

  // Serializer next state; tx_s is the line level for the cycle after the edge.
  always_comb begin
    state_s = state_r;
    baud_s  = baud_r;
    bit_s   = bit_r;
    shift_s = shift_r;
    tx_s    = tx_r;
    pop_s   = 1'b0;
    case (state_r)
      TX_IDLE: begin
        tx_s = UART_IDLE_LEVEL;
        if (!empty_s) begin
          pop_s   = 1'b1;
          shift_s = head_s;
          baud_s  = '0;
          state_s = TX_START;
          tx_s    = UART_START_BIT;
        end else begin
          state_s = TX_IDLE;
        end
      end
      TX_START: begin
        if (baud_r == BAUD_LAST) begin
          baud_s  = '0;
          bit_s   = 3'd0;
          state_s = TX_DATA;
          tx_s    = shift_r[0];
        end else begin
          baud_s = baud_r + BW'(1);
        end
      end
      TX_DATA: begin
        if (baud_r == BAUD_LAST) begin
          baud_s = '0;
          if (bit_r == BIT_LAST) begin
            state_s = TX_STOP;
            tx_s    = UART_STOP_BIT;
          end else begin
            bit_s   = bit_r + 3'd1;
            shift_s = {1'b0, shift_r[UART_DATA_BITS-1:1]};
            tx_s    = shift_r[1];
          end
        end else begin
          baud_s = baud_r + BW'(1);
        end
      end
      TX_STOP: begin
        if (baud_r == BAUD_LAST) begin
          baud_s = '0;
          // Chain straight into the next start bit when more data is queued.
          if (!empty_s) begin
            pop_s   = 1'b1;
            shift_s = head_s;
            state_s = TX_START;
            tx_s    = UART_START_BIT;
          end else begin
            state_s = TX_IDLE;
            tx_s    = UART_IDLE_LEVEL;
          end
        end else begin
          baud_s = baud_r + BW'(1);
        end
      end
      default: begin
        state_s = TX_IDLE;
        baud_s  = '0;
        bit_s   = 3'd0;
        tx_s    = UART_IDLE_LEVEL;
      end
    endcase
  end

  // Serializer registers, line driver and status pulses.
  always_ff @(posedge uartClk or negedge nReset) begin
    if (!nReset) begin
      state_r    <= TX_IDLE;
      baud_r     <= '0;
      bit_r      <= 3'd0;
      shift_r    <= '0;
      tx_r       <= UART_IDLE_LEVEL;
      busy_r     <= 1'b0;
      overflow_r <= 1'b0;
    end else begin
      state_r    <= state_s;
      baud_r     <= baud_s;
      bit_r      <= bit_s;
      shift_r    <= shift_s;
      tx_r       <= tx_s;
      busy_r     <= (state_s != TX_IDLE);
      overflow_r <= bus.wrEn && full_s;
    end
  end

  assign tx           = tx_r;
  assign busy         = busy_r;
  assign bus.full     = full_s;
  assign bus.empty    = empty_s;
  assign bus.level    = level_s;
  assign bus.overflow = overflow_r;

endmodule

// File: tb/tb_uart_tx_buffer.sv
// Bench for uart_tx_buffer: two instances (1 and 4 clocks per bit) share one
// stimulus stream and are compared every cycle against a queue-based line model.
module tb_uart_tx_buffer;

  localparam int DEPTH = 16;

  logic       clk = 1'b0;
  logic       nreset;
  logic [7:0] wr_data;
  logic       wr_en;
  logic       busy1, tx1, busy4, tx4;

  always #5 clk = ~clk;

  uart_tx_buffer_if #(.FIFO_DEPTH(DEPTH)) if1 ();
  uart_tx_buffer_if #(.FIFO_DEPTH(DEPTH)) if4 ();

  assign if1.wrData = wr_data;
  assign if1.wrEn   = wr_en;
  assign if4.wrData = wr_data;
  assign if4.wrEn   = wr_en;

  uart_tx_buffer #(.CLKS_PER_BIT(1), .FIFO_DEPTH(DEPTH)) dut1 (
    .uartClk (clk), .nReset (nreset), .bus (if1), .busy (busy1), .tx (tx1)
  );
  uart_tx_buffer #(.CLKS_PER_BIT(4), .FIFO_DEPTH(DEPTH)) dut4 (
    .uartClk (clk), .nReset (nreset), .bus (if4), .busy (busy4), .tx (tx4)
  );

  // Model: byte queue per instance, plus the position inside the current frame.
  logic [7:0] mq [2][$];
  int         pos [2];
  logic [7:0] cur [2];
  logic       movf [2];
  int         checks = 0;
  int         failures = 0;
  bit         check_en = 1'b0;

  function automatic int cpb_of(input int i);
    return (i == 0) ? 1 : 4;
  endfunction

  function automatic logic exp_tx(input int i);
    int idx;
    if (pos[i] < 0) return 1'b1;
    idx = pos[i] / cpb_of(i);
    if (idx == 0) return 1'b0;
    if (idx == 9) return 1'b1;
    return cur[i][idx-1];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      mq[i].delete();
      pos[i]  = -1;
      cur[i]  = 8'h00;
      movf[i] = 1'b0;
    end
  endtask

  task automatic model_step();
    for (int i = 0; i < 2; i++) begin
      bit pre_full;
      bit pre_ne;
      pre_full = (mq[i].size() == DEPTH);
      pre_ne   = (mq[i].size() != 0);
      movf[i]  = wr_en && pre_full;
      if (pos[i] >= 0) begin
        pos[i]++;
        if (pos[i] == 10 * cpb_of(i)) pos[i] = -1;
      end
      if (pos[i] < 0 && pre_ne) begin
        cur[i] = mq[i].pop_front();
        pos[i] = 0;
      end
      if (wr_en && !pre_full) mq[i].push_back(wr_data);
    end
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s at %0t: actual=%0d expected=%0d", name, $time, act, exp);
    end
  endtask

  // Every-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    if (check_en) begin
      chk("tx1",    int'(tx1),          int'(exp_tx(0)));
      chk("busy1",  int'(busy1),        int'(pos[0] >= 0));
      chk("level1", int'(if1.level),    mq[0].size());
      chk("full1",  int'(if1.full),     int'(mq[0].size() == DEPTH));
      chk("empty1", int'(if1.empty),    int'(mq[0].size() == 0));
      chk("ovf1",   int'(if1.overflow), int'(movf[0]));
      chk("tx4",    int'(tx4),          int'(exp_tx(1)));
      chk("busy4",  int'(busy4),        int'(pos[1] >= 0));
      chk("level4", int'(if4.level),    mq[1].size());
      chk("full4",  int'(if4.full),     int'(mq[1].size() == DEPTH));
      chk("empty4", int'(if4.empty),    int'(mq[1].size() == 0));
      chk("ovf4",   int'(if4.overflow), int'(movf[1]));
    end
  end

  task automatic cycle();
    @(posedge clk);
    if (nreset) model_step();
    @(negedge clk);
  endtask

  task automatic push(input logic [7:0] d);
    wr_en   = 1'b1;
    wr_data = d;
    cycle();
    wr_en   = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((busy1 || busy4 || !if1.empty || !if4.empty) && n < 2000) begin
      cycle();
      n++;
    end
    chk("idle_timeout", int'(n < 2000), 1);
  endtask

  logic [9:0]  seq10;
  logic [19:0] seq20;
  int          bc;
  int          hold_err;
  int          n;
  int          low_cnt;

  initial begin
    nreset  = 1'b0;
    wr_en   = 1'b0;
    wr_data = 8'h00;
    model_reset();
    repeat (3) @(negedge clk);
    chk("rst_tx1",    int'(tx1),       1);
    chk("rst_busy1",  int'(busy1),     0);
    chk("rst_empty1", int'(if1.empty), 1);
    chk("rst_level4", int'(if4.level), 0);
    chk("rst_full4",  int'(if4.full),  0);
    nreset   = 1'b1;
    check_en = 1'b1;
    cycle();

    // Single 0x0F frame at 1 clock/bit.
    push(8'h0F);
    bc = 0;
    for (int k = 0; k < 15; k++) begin
      cycle();
      if (k < 10) seq10[k] = tx1;
      bc += int'(busy1);
    end
    chk("t1_frame", int'(seq10), int'(10'b1000011110));
    chk("t1_busy_cycles", bc, 10);
    wait_idle();

    // Two back-to-back frames, no gap.
    wr_en   = 1'b1;
    wr_data = 8'h0F;
    cycle();
    wr_data = 8'hC9;
    cycle();
    wr_en    = 1'b0;
    seq20[0] = tx1;
    for (int k = 1; k < 20; k++) begin
      cycle();
      seq20[k] = tx1;
    end
    chk("t2_frames", int'(seq20), int'(20'b1110010010_1000011110));
    cycle();
    chk("t2_idle_after", int'(busy1), 0);
    wait_idle();

    // 0xA5 at 4 clocks/bit.
    push(8'hA5);
    bc       = 0;
    hold_err = 0;
    for (int k = 0; k < 45; k++) begin
      cycle();
      if (k < 40) begin
        if (k % 4 == 0) seq10[k/4] = tx4;
        else if (tx4 != seq10[k/4]) hold_err++;
      end
      bc += int'(busy4);
    end
    chk("t3_frame", int'(seq10), int'(10'b1101001010));
    chk("t3_hold", hold_err, 0);
    chk("t3_busy_cycles", bc, 40);
    wait_idle();

    // Fill while busy, then overflow.
    push(8'h11);
    cycle();
    wr_en = 1'b1;
    for (int k = 0; k < 17; k++) begin
      wr_data = 8'($urandom);
      cycle();
      if (k == 15) begin
        chk("t4_level16", int'(if4.level), 16);
        chk("t4_full", int'(if4.full), 1);
      end
    end
    wr_en = 1'b0;
    chk("t4_overflow", int'(if4.overflow), 1);
    chk("t4_level_after", int'(if4.level), 16);
    cycle();
    chk("t4_ovf_pulse", int'(if4.overflow), 0);
    wait_idle();
    chk("t4_empty", int'(if4.empty), 1);

    // Push and pop on the same edge at level 8.
    push(8'h22);
    wr_en = 1'b1;
    for (int k = 0; k < 8; k++) begin
      wr_data = 8'($urandom);
      cycle();
    end
    wr_en = 1'b0;
    chk("t6_level8", int'(if4.level), 8);
    n = 0;
    while (pos[1] != 39 && n < 100) begin
      cycle();
      n++;
    end
    chk("t6_wait", int'(n < 100), 1);
    push(8'($urandom));
    chk("t6_level_same", int'(if4.level), 8);
    wait_idle();

    // Reset during data bit 3 of 0x55 with another byte buffered.
    wr_en   = 1'b1;
    wr_data = 8'h55;
    cycle();
    wr_data = 8'h33;
    cycle();
    wr_en = 1'b0;
    n = 0;
    while (pos[0] != 4 && n < 50) begin
      cycle();
      n++;
    end
    chk("t5_wait", int'(n < 50), 1);
    chk("t5_bit3", int'(tx1), 0);
    #2;
    check_en = 1'b0;
    nreset   = 1'b0;
    #1;
    chk("t5_tx1",    int'(tx1),       1);
    chk("t5_busy1",  int'(busy1),     0);
    chk("t5_level1", int'(if1.level), 0);
    chk("t5_tx4",    int'(tx4),       1);
    chk("t5_level4", int'(if4.level), 0);
    model_reset();
    @(negedge clk);
    nreset   = 1'b1;
    check_en = 1'b1;
    low_cnt  = 0;
    for (int k = 0; k < 50; k++) begin
      cycle();
      low_cnt += int'(!tx1) + int'(!tx4);
    end
    chk("t5_no_frame", low_cnt, 0);

    // Random traffic: light load, then heavy load with overflows and wraps.
    for (int k = 0; k < 400; k++) begin
      wr_en   = ($urandom_range(0, 11) == 0);
      wr_data = 8'($urandom);
      cycle();
    end
    for (int k = 0; k < 400; k++) begin
      wr_en   = ($urandom_range(0, 2) == 0);
      wr_data = 8'($urandom);
      cycle();
    end
    wr_en = 1'b0;
    wait_idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
